// File: rtl/divu_pkg.sv
// Shared types and constants for the sequential unsigned divider.
package divu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } divu_state_t;

    localparam int DIVU_W = 8;

    // Quotient reported when the divisor is zero.
    localparam logic [DIVU_W-1:0] DBZ_QUOT = {DIVU_W{1'b1}};

endpackage

// File: rtl/fadder.sv
// One-bit full adder cell used to build ripple arithmetic.
module fadder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/subu9.sv
// Ripple subtractor a - b built as a + ~b + 1 from fadder cells.
module subu9 #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow_n
);

    logic [N:0] w_carry;

    assign w_carry[0] = 1'b1;

    for (genvar gi = 0; gi < N; gi++) begin : g_bit
        fadder u_fa (
            .a  (a[gi]),
            .b  (~b[gi]),
            .ci (w_carry[gi]),
            .s  (diff[gi]),
            .co (w_carry[gi+1])
        );
    end

    // Final carry-out high means no borrow, i.e. a >= b.
    assign borrow_n = w_carry[N];

endmodule

// File: rtl/divu8_seq.sv
// Sequential restoring unsigned divider: one quotient bit per clock,
// start/in_ready on the input side and out_valid/out_ready on the output side.
module divu8_seq
    import divu_pkg::*;
#(
    parameter int W = DIVU_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic         in_ready,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = $clog2(W) + 1;

    divu_state_t r_state;
    divu_state_t w_state_nxt;

    logic [W-1:0]  r_q;
    logic [W-1:0]  r_d;
    logic [W:0]    r_r;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_quot;
    logic [W-1:0]  r_rem;
    logic          r_dbz;
    logic          r_in_ready;
    logic          r_out_valid;

    logic [W:0]    w_t;
    logic [W:0]    w_diff;
    logic          w_no_borrow;
    logic [W:0]    w_r_nxt;
    logic [W-1:0]  w_q_nxt;
    logic          w_last;
    logic          w_accept;

    // Shift the partial remainder left and bring in the next dividend bit;
    // the shift discards R's top bit, which is always zero after a restore.
    assign w_t = (r_r << 1) | {{W{1'b0}}, r_q[W-1]};

    subu9 #(.N(W + 1)) u_sub (
        .a        (w_t),
        .b        ({1'b0, r_d}),
        .diff     (w_diff),
        .borrow_n (w_no_borrow)
    );

    assign w_r_nxt  = w_no_borrow ? w_diff : w_t;
    assign w_q_nxt  = {r_q[W-2:0], w_no_borrow};
    assign w_last   = (r_cnt == CW'(W - 1));
    assign w_accept = (r_state == IDLE) && start;

    // Next-state logic for the IDLE/CALC/DONE controller.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = (divisor == {W{1'b0}}) ? DONE : CALC;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = CALC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register with handshake flags registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == IDLE);
            r_out_valid <= (w_state_nxt == DONE);
        end
    end

    // Operand latch, iteration datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= {W{1'b0}};
            r_d    <= {W{1'b0}};
            r_r    <= {(W + 1){1'b0}};
            r_cnt  <= {CW{1'b0}};
            r_quot <= {W{1'b0}};
            r_rem  <= {W{1'b0}};
            r_dbz  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_q   <= dividend;
                        r_d   <= divisor;
                        r_r   <= {(W + 1){1'b0}};
                        r_cnt <= {CW{1'b0}};
                        if (divisor == {W{1'b0}}) begin
                            r_quot <= DBZ_QUOT;
                            r_rem  <= dividend;
                            r_dbz  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    r_q   <= w_q_nxt;
                    r_r   <= w_r_nxt;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_quot <= w_q_nxt;
                        r_rem  <= w_r_nxt[W-1:0];
                        r_dbz  <= 1'b0;
                    end
                end
                DONE: begin
                    r_cnt <= r_cnt;
                end
                default: begin
                    r_cnt <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_divu8_seq.sv
// Scoreboard bench for divu8_seq: expected results are queued at accept time
// and compared when the consumer takes the result.
module tb_divu8_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       in_ready;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
    } res_t;

    res_t sb[$];
    int   checks;
    int   failures;

    divu8_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic res_t ref_div(input logic [7:0] a, input logic [7:0] b);
        res_t e;
        if (b == 8'd0) begin
            e.q   = 8'hFF;
            e.r   = a;
            e.dbz = 1'b1;
        end else begin
            e.q   = a / b;
            e.r   = a % b;
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Result is consumed at the next rising edge; compare against the queue head.
    always @(negedge clk) begin
        res_t e;
        if (rst_n && out_valid && out_ready) begin
            chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("quotient", 32'(quotient), 32'(e.q));
                chk("remainder", 32'(remainder), 32'(e.r));
                chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
            end
        end
    end

    task automatic wait_in_ready();
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int bp);
        int   n;
        res_t e;
        wait_in_ready();
        @(posedge clk);
        #2;
        start     = 1'b1;
        dividend  = a;
        divisor   = b;
        out_ready = (bp == 0);
        e = ref_div(a, b);
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", 32'(n), (b == 8'd0) ? 32'd0 : 32'd8);
        for (int i = 0; i < bp; i++) begin
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_quot", 32'(quotient), 32'(e.q));
            chk("bp_rem", 32'(remainder), 32'(e.r));
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_post", 32'(in_ready), 32'd1);
        chk("valid_post", 32'(out_valid), 32'd0);
        chk("hold_quot", 32'(quotient), 32'(e.q));
        chk("hold_rem", 32'(remainder), 32'(e.r));
    endtask

    initial begin
        int n;
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        dividend  = 8'd0;
        divisor   = 8'd0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_quot", 32'(quotient), 32'd0);
        chk("rst_rem", 32'(remainder), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        #1;
        rst_n = 1'b1;

        run_op(8'd200, 8'd7, 0);
        run_op(8'd255, 8'd1, 0);
        run_op(8'd5, 8'd10, 0);
        run_op(8'd255, 8'd255, 0);
        run_op(8'd0, 8'd3, 0);
        run_op(8'd77, 8'd0, 0);
        run_op(8'd100, 8'd9, 20);

        // Busy protection: a second start during CALC must be ignored.
        wait_in_ready();
        @(posedge clk);
        #2;
        start     = 1'b1;
        dividend  = 8'd50;
        divisor   = 8'd3;
        out_ready = 1'b1;
        sb.push_back(ref_div(8'd50, 8'd3));
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("busy_in_ready", 32'(in_ready), 32'd0);
        start    = 1'b1;
        dividend = 8'd9;
        divisor  = 8'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("busy_valid", 32'(out_valid), 32'd1);
        repeat (14) @(posedge clk);
        #1;
        chk("busy_no_second", 32'(out_valid), 32'd0);
        chk("busy_idle", 32'(in_ready), 32'd1);

        // Reset in the middle of CALC aborts the division.
        @(posedge clk);
        #2;
        start     = 1'b1;
        dividend  = 8'd200;
        divisor   = 8'd7;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_quot", 32'(quotient), 32'd0);
        chk("mid_rst_rem", 32'(remainder), 32'd0);
        chk("mid_rst_dbz", 32'(div_by_zero), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        run_op(8'd13, 8'd4, 0);

        // Random sweep, including random backpressure lengths.
        for (int i = 0; i < 1500; i++) begin
            logic [7:0] a;
            logic [7:0] b;
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(1, 255));
            run_op(a, b, (i % 50 == 0) ? 2 : 0);
        end

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
